// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, latency defaults and result type for the mul/div unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // {hi, lo}
    typedef logic [63:0] md_result_t;

    function automatic logic is_md_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - combinational multiply/divide datapath producing {hi, lo}
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output md_result_t  result
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               sgn;
    logic [31:0]        dvd;
    logic [31:0]        dvs;
    logic [31:0]        dvs_safe;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        q;
    logic [31:0]        r;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
    assign sgn      = (op == MD_DIV);
    assign dvd      = (sgn && a[31]) ? (~a + 32'd1) : a;
    assign dvs      = (sgn && b[31]) ? (~b + 32'd1) : b;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign q_mag    = dvd / dvs_safe;
    assign r_mag    = dvd % dvs_safe;
    assign q        = (sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    assign r        = (sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        result = '0;
        case (op)
            MD_MULT:  result = md_result_t'(prod_s);
            MD_MULTU: result = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) result = {a, 32'hFFFF_FFFF};
                else            result = {r, q};
            end
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - mul/div sequencer: busy counter, HI/LO ownership and D-stage stall request
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_instrD,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall,
    output logic        overrun
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    md_result_t         pend;
    md_result_t         core_res;
    logic               arith;
    logic [CNT_W-1:0]   load_cnt;

    muldiv_core u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (core_res)
    );

    assign arith    = is_md_arith(op);
    assign load_cnt = ((op == MD_MULT) || (op == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                             : CNT_W'(DIV_CYCLES);

    // Combinational so the hazard logic can hold D in the same cycle a long op starts in E.
    assign md_stall = md_instrD && (busy || (start && arith));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend    <= '0;
            hi      <= '0;
            lo      <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (arith) begin
                            pend  <= core_res;
                            cnt   <= load_cnt;
                            state <= S_BUSY;
                            busy  <= 1'b1;
                        end else if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                S_BUSY: begin
                    if (start) overrun <= 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi    <= pend[63:32];
                        lo    <= pend[31:0];
                        cnt   <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
